duram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that owns both ports of one duram instance (port A write, port B read).

---
 rtl/duram_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_duram_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/duram_fifo_ctrl.sv
// duram_fifo_ctrl: single-clock FIFO controller that owns both ports of one
// duram instance. Port A is the write port and port B is the read port.
// The RAM registers address_b internally and q_b is unregistered, so pop
// data appears one cycle after an accepted pop. rd_data is q_b passed through.
//
// Optional feature macro: DURAM_FIFO_ERR_EN
//   defined   -> sticky overflow (push while full) and underflow
//                (pop while empty) flags, cleared only by reset
//   undefined -> overflow and underflow are tied to 0
//
// Handshake semantics:
//   push: wr_req is the request and ~full is the ready. A push is accepted
//         (wr_ok) in any cycle where both hold. Data is written to the RAM in
//         that same cycle. A push while full is dropped.
//   pop:  rd_req is the request and ~empty is the ready. A pop is accepted
//         (rd_ok) in any cycle where both hold. rd_valid is high exactly one
//         cycle later, with rd_data valid only in that cycle. A pop while
//         empty is dropped.
//   Both flags are computed from pre-edge pointer state. A word pushed in
//   cycle N can be popped no earlier than cycle N+1.
module duram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wren_a,
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    // Pointers carry one extra wrap bit. This lets full and empty be told
    // apart when the low address bits are equal.
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 ptr_low_eq;
    logic                 ptr_wrap_eq;

    // Status flags and fill level are derived from the pointers alone.
    assign ptr_low_eq  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign ptr_wrap_eq = (wr_ptr[ADDR_WIDTH] == rd_ptr[ADDR_WIDTH]);
    assign empty       = ptr_low_eq & ptr_wrap_eq;
    assign full        = ptr_low_eq & ~ptr_wrap_eq;
    assign usedw       = wr_ptr - rd_ptr;

    // Accepted pushes and pops. Reset blocks the RAM write so that a reset
    // cycle never disturbs RAM contents. A pop in the reset cycle may still
    // move the RAM's internal address register, but reset wins on rd_valid.
    assign wr_ok = wr_req & ~full & ~reset;
    assign rd_ok = rd_req & ~empty;

    // RAM port connections. Read and write addresses only coincide when the
    // FIFO is empty (pop blocked) or full (push blocked). So there is never
    // a same-address read/write in one cycle.
    assign ram_wren_a    = wr_ok;
    assign ram_address_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_data_a    = wr_data;
    assign ram_address_b = rd_ptr[ADDR_WIDTH-1:0];

    // q_b already carries the registered-address read, so it passes straight through.
    assign rd_data = ram_q_b;

    // Pointer advance and the one-cycle read-valid pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            rd_valid <= rd_ok;
        end
    end

`ifdef DURAM_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags. Once set, they stay set until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_req & full) begin
                overflow_q <= 1'b1;
            end
            if (rd_req & empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_duram_fifo_ctrl.sv
// Directed testbench for duram_fifo_ctrl. It uses a behavioural duram model
// with a registered port-B address and an unregistered q_b.
module tb_duram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

`ifdef DURAM_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   usedw;
  logic          overflow;
  logic          underflow;
  logic          ram_wren_a;
  logic [AW-1:0] ram_address_a;
  logic [DW-1:0] ram_data_a;
  logic [AW-1:0] ram_address_b;
  logic [DW-1:0] ram_q_b;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // duram model: port A write, port B address registered, q_b unregistered
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_b_q;
  always @(posedge clock) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    addr_b_q <= ram_address_b;
  end
  assign ram_q_b = mem[addr_b_q];

  duram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .wr_req(wr_req), .wr_data(wr_data), .full(full),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .usedw(usedw),
    .overflow(overflow), .underflow(underflow),
    .ram_wren_a(ram_wren_a), .ram_address_a(ram_address_a), .ram_data_a(ram_data_a),
    .ram_address_b(ram_address_b), .ram_q_b(ram_q_b)
  );

  // driver tasks: drive inputs, cross one rising edge, settle 1 time unit past it
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    wr_req = w; wr_data = d; rd_req = r;
    @(posedge clock); #1;
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (usedw !== 6'd0) begin $display("FAIL reset_usedw got=%0d exp=0", usedw); failures++; end
    checks++; if (empty !== 1'b1) begin $display("FAIL reset_empty got=%b exp=1", empty); failures++; end
    checks++; if (full !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", full); failures++; end
    checks++; if (rd_valid !== 1'b0) begin $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); failures++; end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); failures++; end
  endtask

  task automatic test_single();
    apply_reset();
    wr_req = 1'b1; wr_data = 32'hA5A5_0001; #1;
    checks++; if (ram_wren_a !== 1'b1) begin $display("FAIL single_wren got=%b exp=1", ram_wren_a); failures++; end
    checks++; if (ram_address_a !== 5'd0) begin $display("FAIL single_addr_a got=%0d exp=0", ram_address_a); failures++; end
    checks++; if (ram_data_a !== 32'hA5A5_0001) begin $display("FAIL single_data_a got=%h exp=a5a50001", ram_data_a); failures++; end
    cycle(1'b1, 32'hA5A5_0001, 1'b0);
    checks++; if (usedw !== 6'd1) begin $display("FAIL single_usedw got=%0d exp=1", usedw); failures++; end
    checks++; if (empty !== 1'b0) begin $display("FAIL single_empty got=%b exp=0", empty); failures++; end
    checks++; if (rd_valid !== 1'b0) begin $display("FAIL single_valid_early got=%b exp=0", rd_valid); failures++; end
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_valid !== 1'b1) begin $display("FAIL single_rd_valid got=%b exp=1", rd_valid); failures++; end
    checks++; if (rd_data !== 32'hA5A5_0001) begin $display("FAIL single_rd_data got=%h exp=a5a50001", rd_data); failures++; end
    checks++; if (empty !== 1'b1) begin $display("FAIL single_empty_after got=%b exp=1", empty); failures++; end
    cycle(1'b0, '0, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin $display("FAIL single_valid_drop got=%b exp=0", rd_valid); failures++; end
  endtask

  task automatic test_fill();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_req = 1'b1; wr_data = DW'(i); #1;
      if (ram_address_a !== AW'(i) || ram_wren_a !== 1'b1) bad++;
      cycle(1'b1, DW'(i), 1'b0);
    end
    checks++; if (bad != 0) begin $display("FAIL fill_write_port got=%0d_bad exp=0_bad", bad); failures++; end
    checks++; if (full !== 1'b1) begin $display("FAIL fill_full got=%b exp=1", full); failures++; end
    checks++; if (usedw !== 6'd32) begin $display("FAIL fill_usedw got=%0d exp=32", usedw); failures++; end
    checks++; if (empty !== 1'b0) begin $display("FAIL fill_empty got=%b exp=0", empty); failures++; end
    // 33rd push is rejected
    wr_req = 1'b1; wr_data = 32'hDEAD_BEEF; #1;
    checks++; if (ram_wren_a !== 1'b0) begin $display("FAIL over_wren got=%b exp=0", ram_wren_a); failures++; end
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    checks++; if (usedw !== 6'd32) begin $display("FAIL over_usedw got=%0d exp=32", usedw); failures++; end
    checks++; if (overflow !== ERR_EN) begin $display("FAIL over_flag got=%b exp=%b", overflow, ERR_EN); failures++; end
    // push+pop at full: pop accepted, push rejected
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      $display("FAIL full_pushpop_data got=%b/%h exp=1/0", rd_valid, rd_data); failures++; end
    checks++; if (usedw !== 6'd31) begin $display("FAIL full_pushpop_usedw got=%0d exp=31", usedw); failures++; end
    bad = 0;
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        if (bad == 0) $display("FAIL drain_data idx=%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, i);
        bad++;
      end
    end
    checks++; if (bad != 0) begin $display("FAIL drain_order got=%0d_bad exp=0_bad", bad); failures++; end
    checks++; if (empty !== 1'b1 || usedw !== 6'd0) begin
      $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, usedw); failures++; end
    checks++; if (underflow !== 1'b0) begin $display("FAIL drain_underflow got=%b exp=0", underflow); failures++; end
  endtask

  task automatic test_wrap();
    int bad;
    apply_reset();
    bad = 0;
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < 20; i++) begin
        wr_req = 1'b1; wr_data = DW'(32'h100 * (rnd + 1) + i); #1;
        if (ram_address_a !== AW'(rnd * 20 + i)) bad++;
        cycle(1'b1, DW'(32'h100 * (rnd + 1) + i), 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
        cycle(1'b0, '0, 1'b1);
        if (rd_valid !== 1'b1 || rd_data !== DW'(32'h100 * (rnd + 1) + i)) begin
          if (bad == 0) $display("FAIL wrap_data rnd=%0d idx=%0d got=%h", rnd, i, rd_data);
          bad++;
        end
      end
    end
    checks++; if (bad != 0) begin $display("FAIL wrap_order got=%0d_bad exp=0_bad", bad); failures++; end
    checks++; if (usedw !== 6'd0 || empty !== 1'b1) begin
      $display("FAIL wrap_usedw got=%0d/%b exp=0/1", usedw, empty); failures++; end
    checks++; if (ram_address_b !== 5'd8) begin $display("FAIL wrap_addr_b got=%0d exp=8", ram_address_b); failures++; end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [DW-1:0] exp_q[$];
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, DW'(32'h300 + k), 1'b0);
      exp_q.push_back(DW'(32'h300 + k));
    end
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      cycle(1'b1, DW'(32'h305 + j), 1'b1);
      exp_q.push_back(DW'(32'h305 + j));
      if (usedw !== 6'd5) bad++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q.pop_front()) bad++;
    end
    checks++; if (bad != 0) begin $display("FAIL b2b_stream got=%0d_bad exp=0_bad", bad); failures++; end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (rd_valid !== 1'b1 || rd_data !== exp_q.pop_front()) bad++;
    end
    checks++; if (bad != 0) begin $display("FAIL b2b_drain got=%0d_bad exp=0_bad", bad); failures++; end
    checks++; if (empty !== 1'b1) begin $display("FAIL b2b_empty got=%b exp=1", empty); failures++; end
  endtask

  // runs after test_back_to_back without reset, so both pointers sit at 15
  task automatic test_underflow();
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_valid !== 1'b0) begin $display("FAIL under_rd_valid got=%b exp=0", rd_valid); failures++; end
    checks++; if (ram_address_b !== 5'd15 || ram_address_a !== 5'd15) begin
      $display("FAIL under_ptrs got=%0d/%0d exp=15/15", ram_address_a, ram_address_b); failures++; end
    checks++; if (usedw !== 6'd0 || empty !== 1'b1) begin
      $display("FAIL under_level got=%0d/%b exp=0/1", usedw, empty); failures++; end
    checks++; if (underflow !== ERR_EN) begin $display("FAIL under_flag got=%b exp=%b", underflow, ERR_EN); failures++; end
    cycle(1'b0, '0, 1'b0);
    checks++; if (underflow !== ERR_EN) begin $display("FAIL under_sticky got=%b exp=%b", underflow, ERR_EN); failures++; end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 12; k++) cycle(1'b1, DW'(32'h400 + k), 1'b0);
    checks++; if (usedw !== 6'd12) begin $display("FAIL mid_usedw_pre got=%0d exp=12", usedw); failures++; end
    reset = 1'b1; wr_req = 1'b1; wr_data = 32'h0BAD_0BAD; rd_req = 1'b1; #1;
    checks++; if (ram_wren_a !== 1'b0) begin $display("FAIL mid_wren got=%b exp=0", ram_wren_a); failures++; end
    @(posedge clock); #1;
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    checks++; if (usedw !== 6'd0 || empty !== 1'b1) begin
      $display("FAIL mid_level got=%0d/%b exp=0/1", usedw, empty); failures++; end
    checks++; if (rd_valid !== 1'b0) begin $display("FAIL mid_rd_valid got=%b exp=0", rd_valid); failures++; end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL mid_flags got=%b%b exp=00", overflow, underflow); failures++; end
    cycle(1'b1, 32'h0000_5555, 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_5555) begin
      $display("FAIL mid_restart got=%b/%h exp=1/00005555", rd_valid, rd_data); failures++; end
  endtask

  initial begin
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_underflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
